banco_de_registros_multipuerto: RTL and testbench
=================================================

// Module: banco_de_registros_multipuerto
// PURPOSE
//  Parametrised register bank: N words of M bits, two write ports, two read ports.
//  Generalises the single-register, dual-write-enable block to an addressed array.
//  Adds per-word valid tracking, optional write-to-read bypass and collision reporting.
//  Sits between the datapath ALU/load paths (writers) and operand fetch (readers).
// PARAMETERS
//  M          32  data width in bits
//  N          16  number of words; power of two, >=2; AW = $clog2(N) is a localparam
//  REG0_ZERO   1  1: word 0 hard-wired to zero, writes to it ignored
//  BYPASS      1  1: a read of an address written this cycle returns the write data
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  w1         in   1   write enable, port 1 (priority port)
//  addr_w1    in   AW  write address, port 1
//  data_in1   in   M   write data, port 1
//  w2         in   1   write enable, port 2
//  addr_w2    in   AW  write address, port 2
//  data_in2   in   M   write data, port 2
//  addr_r1    in   AW  read address, port 1
//  addr_r2    in   AW  read address, port 2
//  out1       out  M   read data, port 1 (combinational from addr_r1)
//  out2       out  M   read data, port 2 (combinational from addr_r2)
//  valid1     out  1   word at addr_r1 written since last reset
//  valid2     out  1   word at addr_r2 written since last reset
//  collision  out  1   registered: previous cycle had w1&w2 to the same address
// BEHAVIOUR
//  Reset (rst=1 at posedge): all words <= 0, all valid bits <= 0, collision <= 0.
//   rst overrides w1/w2 in the same cycle; no write takes effect.
//  Writes (rst=0): at posedge, if w1, word[addr_w1] <= data_in1, valid[addr_w1] <= 1;
//   if w2, word[addr_w2] <= data_in2, valid[addr_w2] <= 1.
//  Same-address double write: port 1 wins; data_in2 discarded; collision = 1 next cycle,
//   for exactly one cycle unless the condition repeats. Different addresses: both commit.
//  REG0_ZERO=1: writes to address 0 ignored (no collision reported for them);
//   reads of address 0 give out=0, valid=1 in and out of reset.
//  Reads: out/valid are combinational from the array, zero-cycle latency.
//   BYPASS=0: a read of a word written this cycle shows the old value until after the edge.
//   BYPASS=1: if rst=0 and a live write targets the read address, out = write data
//   (port 1 data if both target it), valid = 1. Bypass is suppressed when rst=1,
//   and for address 0 when REG0_ZERO=1.
//  Both read ports are independent; addr_r1 == addr_r2 legal, identical results.
//  Reset mid-operation: one rst cycle clears everything; the next cycle's writes commit normally.
//  No X propagation: all outputs defined from the first posedge with rst=1.
// STRUCTURE
//  Shared package banco_pkg: default M/N, zero-word constant, read-mux function signature.
//  One sub-module, banco_lectura: address decode + bypass mux for one read port,
//   instantiated twice (port 1, port 2). Write logic and collision flop stay in top.
// TESTING
//  1 rst=1 one cycle, then read every address -> out=0, valid=0 (addr 0: valid=1).
//  2 w1 addr 3 data 0xA5A5_0003; next cycle addr_r1=3 -> out1=0xA5A5_0003, valid1=1.
//  3 w1 addr 5 0x11, w2 addr 5 0x22 same cycle -> word5=0x11, collision=1 one cycle, then 0.
//  4 w1 addr 2 0x33, w2 addr 7 0x44 -> both stored; collision stays 0.
//  5 BYPASS=1: w2 addr 9 0x55, addr_r2=9 same cycle -> out2=0x55 before edge; BYPASS=0 -> old value.
//  6 REG0_ZERO=1: w1 addr 0 0xFFFF_FFFF -> out=0; rst with w1 addr 4 -> word4=0, valid=0.

Source files
------------

// File: rtl/banco_pkg.sv
// Shared definitions for the multiport register bank: default sizes, the zero word
// and the read-source selection used by every read port.
package banco_pkg;

    localparam int M_DEF = 32;
    localparam int N_DEF = 16;

    localparam logic [M_DEF-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        SRC_ARRAY,
        SRC_ZERO,
        SRC_W1,
        SRC_W2
    } rd_src_e;

    // Hard-wired zero beats any bypass; port 1 write data beats port 2.
    function automatic rd_src_e rd_select(input logic is_zero, input logic hit1, input logic hit2);
        if (is_zero) return SRC_ZERO;
        if (hit1)    return SRC_W1;
        if (hit2)    return SRC_W2;
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/banco_de_registros_multipuerto_if.sv
// Write/read bus of the register bank: writers and operand fetch act as master,
// the bank is the slave.
interface banco_de_registros_multipuerto_if
    import banco_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
);
    localparam int AW = $clog2(N);

    logic          w1;
    logic [AW-1:0] addr_w1;
    logic [M-1:0]  data_in1;
    logic          w2;
    logic [AW-1:0] addr_w2;
    logic [M-1:0]  data_in2;
    logic [AW-1:0] addr_r1;
    logic [AW-1:0] addr_r2;
    logic [M-1:0]  out1;
    logic [M-1:0]  out2;
    logic          valid1;
    logic          valid2;
    logic          collision;

    modport master (
        output w1, addr_w1, data_in1, w2, addr_w2, data_in2, addr_r1, addr_r2,
        input  out1, out2, valid1, valid2, collision
    );

    modport slave (
        input  w1, addr_w1, data_in1, w2, addr_w2, data_in2, addr_r1, addr_r2,
        output out1, out2, valid1, valid2, collision
    );

endinterface

// File: rtl/banco_lectura.sv
// One combinational read port: address decode into the array plus the optional
// same-cycle write bypass.
module banco_lectura
    import banco_pkg::*;
#(
    parameter int M         = M_DEF,
    parameter int N         = N_DEF,
    parameter int REG0_ZERO = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(N)
) (
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [M-1:0]  mem [N],
    input  logic [N-1:0]  valid_bits,
    input  logic          w1,
    input  logic [AW-1:0] addr_w1,
    input  logic [M-1:0]  data_in1,
    input  logic          w2,
    input  logic [AW-1:0] addr_w2,
    input  logic [M-1:0]  data_in2,
    output logic [M-1:0]  data,
    output logic          valid
);

    logic    is_zero;
    logic    hit1;
    logic    hit2;
    rd_src_e src;

    // Bypass is disabled while in reset: the write it would forward never commits.
    assign is_zero = (REG0_ZERO != 0) && (addr == '0);
    assign hit1    = (BYPASS != 0) && !rst && w1 && (addr_w1 == addr);
    assign hit2    = (BYPASS != 0) && !rst && w2 && (addr_w2 == addr);
    assign src     = rd_select(is_zero, hit1, hit2);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        data  = mem[addr];
        valid = valid_bits[addr];
        case (src)
            SRC_ZERO: begin
                data  = M'(ZERO_WORD);
                valid = 1'b1;
            end
            SRC_W1: begin
                data  = data_in1;
                valid = 1'b1;
            end
            SRC_W2: begin
                data  = data_in2;
                valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/banco_de_registros_multipuerto.sv
// N x M register bank with two write ports (port 1 has priority), two bypassable
// read ports, per-word valid bits and a registered same-address collision flag.
module banco_de_registros_multipuerto
    import banco_pkg::*;
#(
    parameter int M         = M_DEF,
    parameter int N         = N_DEF,
    parameter int REG0_ZERO = 1,
    parameter int BYPASS    = 1
) (
    input  logic clk,
    input  logic rst,
    banco_de_registros_multipuerto_if.slave bus
);

    logic [M-1:0] mem [N];
    logic [N-1:0] valid_bits;
    logic         wr1_ok;
    logic         wr2_ok;

    // Writes aimed at a hard-wired zero word are dropped entirely, including for collision.
    assign wr1_ok = bus.w1 && !((REG0_ZERO != 0) && (bus.addr_w1 == '0));
    assign wr2_ok = bus.w2 && !((REG0_ZERO != 0) && (bus.addr_w2 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is built from flops, not a RAM macro, so it can and must be cleared on reset.
            for (int i = 0; i < N; i++) mem[i] <= '0;
            valid_bits   <= '0;
            bus.collision <= 1'b0;
        end else begin
            // NOTE: non-blocking, so port 1's later assignment wins when both target one word.
            if (wr2_ok) begin
                mem[bus.addr_w2]        <= bus.data_in2;
                valid_bits[bus.addr_w2] <= 1'b1;
            end
            if (wr1_ok) begin
                mem[bus.addr_w1]        <= bus.data_in1;
                valid_bits[bus.addr_w1] <= 1'b1;
            end
            bus.collision <= wr1_ok && wr2_ok && (bus.addr_w1 == bus.addr_w2);
        end
    end

    banco_lectura #(.M(M), .N(N), .REG0_ZERO(REG0_ZERO), .BYPASS(BYPASS)) u_rd1 (
        .rst        (rst),
        .addr       (bus.addr_r1),
        .mem        (mem),
        .valid_bits (valid_bits),
        .w1         (bus.w1),
        .addr_w1    (bus.addr_w1),
        .data_in1   (bus.data_in1),
        .w2         (bus.w2),
        .addr_w2    (bus.addr_w2),
        .data_in2   (bus.data_in2),
        .data       (bus.out1),
        .valid      (bus.valid1)
    );

    banco_lectura #(.M(M), .N(N), .REG0_ZERO(REG0_ZERO), .BYPASS(BYPASS)) u_rd2 (
        .rst        (rst),
        .addr       (bus.addr_r2),
        .mem        (mem),
        .valid_bits (valid_bits),
        .w1         (bus.w1),
        .addr_w1    (bus.addr_w1),
        .data_in1   (bus.data_in1),
        .w2         (bus.w2),
        .addr_w2    (bus.addr_w2),
        .data_in2   (bus.data_in2),
        .data       (bus.out2),
        .valid      (bus.valid2)
    );

endmodule

// File: tb/tb_banco_de_registros_multipuerto.sv
// Directed bench for the register bank: one instance with bypass, one without,
// both driven by the same stimulus.
module tb_banco_de_registros_multipuerto;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    banco_de_registros_multipuerto_if #(.M(32), .N(16)) bus ();
    banco_de_registros_multipuerto_if #(.M(32), .N(16)) bus_b ();

    assign bus_b.w1       = bus.w1;
    assign bus_b.addr_w1  = bus.addr_w1;
    assign bus_b.data_in1 = bus.data_in1;
    assign bus_b.w2       = bus.w2;
    assign bus_b.addr_w2  = bus.addr_w2;
    assign bus_b.data_in2 = bus.data_in2;
    assign bus_b.addr_r1  = bus.addr_r1;
    assign bus_b.addr_r2  = bus.addr_r2;

    banco_de_registros_multipuerto #(.M(32), .N(16), .REG0_ZERO(1), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    banco_de_registros_multipuerto #(.M(32), .N(16), .REG0_ZERO(1), .BYPASS(0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        bus.w1 = 1'b0;
        bus.w2 = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.w1       = 1'b0;
        bus.addr_w1  = '0;
        bus.data_in1 = '0;
        bus.w2       = 1'b0;
        bus.addr_w2  = '0;
        bus.data_in2 = '0;
        bus.addr_r1  = '0;
        bus.addr_r2  = '0;

        // 1: reset then every address reads zero, only word 0 valid
        edge_step();
        rst = 1'b0;
        #1;
        check("rst_collision", {31'b0, bus.collision}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus.addr_r1 = 4'(i);
            bus.addr_r2 = 4'(15 - i);
            #1;
            check($sformatf("rst_out1_a%0d", i), bus.out1, 32'd0);
            check($sformatf("rst_valid1_a%0d", i), {31'b0, bus.valid1}, (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("rst_out2_a%0d", 15 - i), bus.out2, 32'd0);
            check($sformatf("rst_valid2_a%0d", 15 - i), {31'b0, bus.valid2}, (i == 15) ? 32'd1 : 32'd0);
        end

        // 2: single write on port 1
        edge_step();
        bus.w1 = 1'b1; bus.addr_w1 = 4'd3; bus.data_in1 = 32'hA5A5_0003;
        edge_step();
        clear_writes();
        bus.addr_r1 = 4'd3;
        #1;
        check("wr3_out1", bus.out1, 32'hA5A5_0003);
        check("wr3_valid1", {31'b0, bus.valid1}, 32'd1);
        check("wr3_nb_out1", bus_b.out1, 32'hA5A5_0003);

        // 3: same-address double write, port 1 wins, collision one cycle
        bus.w1 = 1'b1; bus.addr_w1 = 4'd5; bus.data_in1 = 32'h11;
        bus.w2 = 1'b1; bus.addr_w2 = 4'd5; bus.data_in2 = 32'h22;
        edge_step();
        clear_writes();
        bus.addr_r1 = 4'd5;
        #1;
        check("coll_word5", bus.out1, 32'h11);
        check("coll_flag", {31'b0, bus.collision}, 32'd1);
        edge_step();
        check("coll_clear", {31'b0, bus.collision}, 32'd0);

        // 4: different addresses, both commit, no collision
        bus.w1 = 1'b1; bus.addr_w1 = 4'd2; bus.data_in1 = 32'h33;
        bus.w2 = 1'b1; bus.addr_w2 = 4'd7; bus.data_in2 = 32'h44;
        edge_step();
        clear_writes();
        bus.addr_r1 = 4'd2;
        bus.addr_r2 = 4'd7;
        #1;
        check("diff_out1", bus.out1, 32'h33);
        check("diff_out2", bus.out2, 32'h44);
        check("diff_valid2", {31'b0, bus.valid2}, 32'd1);
        check("diff_collision", {31'b0, bus.collision}, 32'd0);

        // 5: bypass versus no bypass, then port 1 bypass priority
        bus.w2 = 1'b1; bus.addr_w2 = 4'd9; bus.data_in2 = 32'h55;
        bus.addr_r2 = 4'd9;
        bus.addr_r1 = 4'd9;
        #1;
        check("byp_out2", bus.out2, 32'h55);
        check("byp_valid2", {31'b0, bus.valid2}, 32'd1);
        check("nobyp_out2", bus_b.out2, 32'd0);
        check("nobyp_valid2", {31'b0, bus_b.valid2}, 32'd0);
        bus.w1 = 1'b1; bus.addr_w1 = 4'd9; bus.data_in1 = 32'h66;
        #1;
        check("byp_prio_out1", bus.out1, 32'h66);
        check("byp_prio_out2", bus.out2, 32'h66);
        edge_step();
        clear_writes();
        #1;
        check("byp_commit_nb", bus_b.out2, 32'h66);
        check("byp_collision", {31'b0, bus.collision}, 32'd1);

        // 6: writes to address 0 are ignored and never collide
        edge_step();
        bus.w1 = 1'b1; bus.addr_w1 = 4'd0; bus.data_in1 = 32'hFFFF_FFFF;
        bus.w2 = 1'b1; bus.addr_w2 = 4'd0; bus.data_in2 = 32'h1234_5678;
        bus.addr_r1 = 4'd0;
        #1;
        check("z0_byp_out1", bus.out1, 32'd0);
        check("z0_byp_valid1", {31'b0, bus.valid1}, 32'd1);
        edge_step();
        clear_writes();
        #1;
        check("z0_out1", bus.out1, 32'd0);
        check("z0_collision", {31'b0, bus.collision}, 32'd0);

        // reset with a concurrent write: bypass suppressed, write discarded, all cleared
        rst = 1'b1;
        bus.w1 = 1'b1; bus.addr_w1 = 4'd4; bus.data_in1 = 32'h77;
        bus.addr_r1 = 4'd4;
        bus.addr_r2 = 4'd3;
        #1;
        check("rstw_byp_out1", bus.out1, 32'd0);
        check("rstw_byp_valid1", {31'b0, bus.valid1}, 32'd0);
        check("rstw_pre_out2", bus.out2, 32'hA5A5_0003);
        edge_step();
        clear_writes();
        rst = 1'b0;
        #1;
        check("rstw_out1", bus.out1, 32'd0);
        check("rstw_valid1", {31'b0, bus.valid1}, 32'd0);
        check("rstw_out2", bus.out2, 32'd0);
        check("rstw_valid2", {31'b0, bus.valid2}, 32'd0);
        bus.addr_r2 = 4'd0;
        #1;
        check("rstw_valid0", {31'b0, bus.valid2}, 32'd1);

        // recovery: first write after reset commits normally
        bus.w1 = 1'b1; bus.addr_w1 = 4'd4; bus.data_in1 = 32'h88;
        edge_step();
        clear_writes();
        #1;
        check("recov_out1", bus.out1, 32'h88);
        check("recov_valid1", {31'b0, bus.valid1}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
